// File: rtl/router_1_arbiter_pkg.sv
// Shared definitions for the router_1 output-port arbiter: crossbar port codes,
// credit counter width and the round-robin pick helper.
package router_1_arbiter_pkg;

  localparam logic [2:0] W_PORT  = 3'd2;
  localparam logic [2:0] S_PORT  = 3'd3;
  localparam logic [2:0] L_PORT  = 3'd4;
  localparam logic [2:0] NO_PORT = 3'd7;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    PTR_W = 2'd0,
    PTR_S = 2'd1,
    PTR_L = 2'd2
  } port_e;

  // Cyclic W->S->L->W search that starts just after the last-granted port.
  // Only meaningful when at least one request is high.
  function automatic port_e rr_pick(input port_e last, input logic w_req,
                                    input logic s_req, input logic l_req);
    port_e win;
    win = PTR_W;
    case (last)
      PTR_W:   win = s_req ? PTR_S : (l_req ? PTR_L : PTR_W);
      PTR_S:   win = l_req ? PTR_L : (w_req ? PTR_W : PTR_S);
      default: win = w_req ? PTR_W : (s_req ? PTR_S : PTR_L);
    endcase
    return win;
  endfunction

endpackage

// File: rtl/router_1_arbiter_if.sv
// Bundle between the three input FIFOs, the arbiter and the downstream credit
// return. master = upstream side, slave = arbiter.
interface router_1_arbiter_if;

  // Handshake: x_req says the FIFO head is valid and routed here; x_grant is a
  // same-cycle pop strobe, asserted only while x_req is high and a credit is free.
  logic       W_req;
  logic       S_req;
  logic       L_req;
  logic       W_tail;
  logic       S_tail;
  logic       L_tail;
  logic       credit_in;
  logic [2:0] sel_out;
  logic       W_grant;
  logic       S_grant;
  logic       L_grant;
  logic       credit_err;

  modport master (
    output W_req, S_req, L_req, W_tail, S_tail, L_tail, credit_in,
    input  sel_out, W_grant, S_grant, L_grant, credit_err
  );

  modport slave (
    input  W_req, S_req, L_req, W_tail, S_tail, L_tail, credit_in,
    output sel_out, W_grant, S_grant, L_grant, credit_err
  );

endinterface

// File: rtl/router_1_credit_cnt.sv
// Downstream buffer credit counter with saturation and a sticky overflow flag
// raised when a credit returns while the counter is already full.
module router_1_credit_cnt
  import router_1_arbiter_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] credits_o,
  output logic             avail_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A transfer and a returned credit in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    case ({dec_i, inc_i})
      2'b10: cnt_d = cnt_q - ONE;
      2'b01: begin
        if (cnt_q == FULL) err_d = 1'b1;
        else               cnt_d = cnt_q + ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= FULL;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign credits_o = cnt_q;
  assign avail_o   = (cnt_q != '0);
  assign err_o     = err_q;

endmodule

// File: rtl/router_1_arbiter.sv
// Round-robin wormhole arbiter for one router output port: locks onto a packet
// from W, S or L until its tail flit, gated by downstream credits.
module router_1_arbiter
  import router_1_arbiter_pkg::*;
#(
  parameter int CREDITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  router_1_arbiter_if.slave      bus,
  output logic [1:0]             state_o,
  output logic [1:0]             ptr_o,
  output logic [CNT_W-1:0]       credits_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_W = 2'd1,
    GNT_S = 2'd2,
    GNT_L = 2'd3
  } state_e;

  state_e     state_q, state_d;
  port_e      ptr_q, ptr_d;
  port_e      winner;
  logic       any_req;
  logic       avail;
  logic       xfer;
  logic       gnt_w, gnt_s, gnt_l;
  logic [2:0] sel;

  assign any_req = bus.W_req | bus.S_req | bus.L_req;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    xfer    = 1'b0;
    gnt_w   = 1'b0;
    gnt_s   = 1'b0;
    gnt_l   = 1'b0;
    sel     = NO_PORT;
    winner  = rr_pick(ptr_q, bus.W_req, bus.S_req, bus.L_req);
    case (state_q)
      IDLE: begin
        if (any_req) begin
          ptr_d = winner;
          case (winner)
            PTR_W:   state_d = GNT_W;
            PTR_S:   state_d = GNT_S;
            default: state_d = GNT_L;
          endcase
        end
      end
      // While locked, other ports are ignored; no request or no credit = stall.
      GNT_W: begin
        if (bus.W_req && avail) begin
          xfer  = 1'b1;
          gnt_w = 1'b1;
          sel   = W_PORT;
          if (bus.W_tail) state_d = IDLE;
        end
      end
      GNT_S: begin
        if (bus.S_req && avail) begin
          xfer  = 1'b1;
          gnt_s = 1'b1;
          sel   = S_PORT;
          if (bus.S_tail) state_d = IDLE;
        end
      end
      default: begin
        if (bus.L_req && avail) begin
          xfer  = 1'b1;
          gnt_l = 1'b1;
          sel   = L_PORT;
          if (bus.L_tail) state_d = IDLE;
        end
      end
    endcase
    // A reset cycle never pops a FIFO, even if the lock was active.
    if (!rst) begin
      xfer  = 1'b0;
      gnt_w = 1'b0;
      gnt_s = 1'b0;
      gnt_l = 1'b0;
      sel   = NO_PORT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= PTR_L;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  router_1_credit_cnt #(
    .CREDITS (CREDITS)
  ) u_credit_cnt (
    .clk       (clk),
    .rst       (rst),
    .dec_i     (xfer),
    .inc_i     (bus.credit_in),
    .credits_o (credits_o),
    .avail_o   (avail),
    .err_o     (bus.credit_err)
  );

  assign bus.W_grant = gnt_w;
  assign bus.S_grant = gnt_s;
  assign bus.L_grant = gnt_l;
  assign bus.sel_out = sel;
  assign state_o     = state_q;
  assign ptr_o       = ptr_q;

endmodule
